clock_phase_sequencer: RTL and testbench
========================================

# clock_phase_sequencer

Single-clock enable sequencer that replaces fixed divide-by-2/divide-by-4 derived clocks with per-channel, one-cycle clock-enable pulses. Every memory, register-file and processor stage runs on `clock` and samples only when its enable is high. Per-channel ratio and phase are runtime-programmable. A halt/single-step state machine freezes all stages on a frame boundary for debug. The block sits at the top level beside the processor, imem, dmem and regfile.

## Interface
- `NUM_CH`, default 4: number of enable channels (ch0 imem, ch1 dmem, ch2 processor, ch3 regfile by convention).
- `FRAME_LOG2`, default 2, legal range 1..7: the frame is 2^FRAME_LOG2 cycles long.
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: write the shadow config for channel `cfg_ch`.
- `cfg_ch` in clog2(NUM_CH): target channel. Values ≥ NUM_CH are ignored.
- `cfg_div_log2` in 3: channel period is 2^cfg_div_log2. Values > FRAME_LOG2 are clamped to FRAME_LOG2.
- `cfg_phase` in FRAME_LOG2: pulse offset inside the period. It is masked to (period−1).
- `halt_req` in 1: level request to stop at the next frame boundary.
- `step` in 1: one-cycle pulse. Honoured only in HALTED.
- `en` out NUM_CH: per-channel clock-enable pulses.
- `frame_start` out 1: high in the first cycle of each executed frame.
- `halted` out 1: high while in HALTED.
- `cfg_pending` out 1: shadow config holds uncommitted writes.

## Operation
- Internal `frame_cnt` is FRAME_LOG2 bits. It advances by 1 per cycle in RUN and STEP and wraps from FRAME−1 to 0.
- `en[i]` = running && ((frame_cnt & (2^div[i]−1)) == phase[i]), where running = (state ≠ HALTED).
  - Outputs are combinational from registered state only.
- `frame_start` = running && frame_cnt == 0.
- Reset config:
  - ch0: div_log2 = 0, phase = 0 (pulses every cycle).
  - ch1: div_log2 = 1, phase = 1.
  - All other channels: div_log2 = FRAME_LOG2, phase = FRAME−1.
  - Shadow config equals active config. Reset state is RUN, frame_cnt = 0.
- Config write:
  - `cfg_we` updates that channel's shadow register and sets the pending flag. This is legal in any state.
  - Shadow is copied to active on the commit cycle: the cycle where frame_cnt == FRAME−1 in RUN/STEP, or any cycle in HALTED. The pending flag clears on commit.
  - A `cfg_we` in the commit cycle itself is not included. It commits at the next boundary, and `cfg_pending` stays high.
- State machine, with B = (frame_cnt == FRAME−1):
  - RUN, B && halt_req → HALTED. frame_cnt becomes 0.
  - RUN otherwise → RUN.
  - HALTED, step → STEP. frame_cnt stays 0.
  - HALTED, !halt_req && !step → RUN.
  - HALTED, halt_req && !step → HALTED.
  - STEP, B → HALTED if halt_req, else RUN.
  - STEP otherwise → STEP.
  - `step` has priority over release in HALTED.
  - `step` outside HALTED is ignored. It is not queued.
- HALTED holds frame_cnt at 0 and forces all `en` to 0. Resuming always restarts at frame_cnt = 0, so channel alignment is preserved.
- Mid-operation reset forces the reset state on the next edge, regardless of state or pending config. All pending writes are discarded.

## Timing
- While `reset` is high: `en` = 0, `frame_start` = 0, `halted` = 0, `cfg_pending` = 0. Outputs are gated directly by `reset`.
- First cycle after reset release: frame_cnt = 0, `frame_start` = 1, `en[0]` = 1.
- Enable pattern at defaults with FRAME_LOG2 = 2 (FRAME = 4):
  - ch0: every cycle.
  - ch1: counts 1 and 3.
  - ch2 and ch3: count 3.
- Halt latency:
  - `halt_req` sampled high at B → `halted` = 1 on the next cycle.
  - Worst case is FRAME cycles from assertion.
  - The frame in progress always completes, including its last-slot enables.
- Release latency: `halt_req` low in HALTED → RUN on the next cycle, with `frame_start` = 1.
- A step executes exactly FRAME cycles of enables. The STEP state starts the cycle after the `step` pulse.
- Config latency:
  - Written in RUN: takes effect at frame_cnt = 0 of the next frame (1..FRAME cycles).
  - Written in HALTED: takes effect on the next cycle.

## Test plan
- Reset then run 12 cycles, FRAME_LOG2 = 2 → ch0 pulses 12 times, ch1 pulses 6 times (counts 1 and 3), ch2 and ch3 pulse 3 times (count 3), `frame_start` fires at cycles 0, 4 and 8.
- Assert `halt_req` at frame_cnt = 1 → ch2 still pulses at count 3, `halted` = 1 the next cycle, all `en` = 0; deassert → RUN with `frame_start` = 1 the next cycle.
- In HALTED, pulse `step` with `halt_req` held high → exactly 4 cycles of enables (ch0 ×4, ch2 ×1), then `halted` = 1 again; `step` while in RUN → no effect.
- In RUN, write ch1 div_log2 = 2, phase = 2 at frame_cnt = 1 → `cfg_pending` = 1 and the old ch1 pattern continues to the end of the frame; from the next frame ch1 pulses only at count 2 and `cfg_pending` = 0.
- Write a config in the commit cycle (frame_cnt = 3) → it is applied one frame later and `cfg_pending` stays high across the boundary; write cfg_div_log2 = 7 → behaves as 2; write cfg_ch = NUM_CH → no change.
- Assert `reset` in STEP with a config write pending → next cycle shows the default pattern, `halted` = 0, `cfg_pending` = 0.

Source files
------------

// File: rtl/clock_phase_sequencer.sv
// clock_phase_sequencer: single-clock enable sequencer.
// Each channel gets a one-cycle enable pulse per programmable period within
// a fixed-length frame. A halt / single-step machine freezes all channels on
// frame boundaries. Config is double-buffered: writes land in a shadow copy
// and are committed to the active copy only on frame boundaries (or while
// halted), so channel alignment never glitches mid-frame.
module clock_phase_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int FRAME_LOG2 = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [2:0]            cfg_div_log2,
    input  logic [FRAME_LOG2-1:0] cfg_phase,
    input  logic                  halt_req,
    input  logic                  step,
    output logic [NUM_CH-1:0]     en,
    output logic                  frame_start,
    output logic                  halted,
    output logic                  cfg_pending
);

    localparam int unsigned    NCH      = NUM_CH;
    localparam logic [2:0]     DIV_MAX  = 3'(FRAME_LOG2);
    localparam logic [CH_W:0]  CH_LIMIT = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_STEP
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;

    // Active config drives the enables; shadow config collects writes.
    logic [2:0]            adiv_q [NUM_CH];
    logic [2:0]            adiv_d [NUM_CH];
    logic [FRAME_LOG2-1:0] aph_q  [NUM_CH];
    logic [FRAME_LOG2-1:0] aph_d  [NUM_CH];
    logic [2:0]            sdiv_q [NUM_CH];
    logic [2:0]            sdiv_d [NUM_CH];
    logic [FRAME_LOG2-1:0] sph_q  [NUM_CH];
    logic [FRAME_LOG2-1:0] sph_d  [NUM_CH];
    logic                  pend_q, pend_d;

    logic                  last_slot;
    logic                  commit;
    logic                  cfg_hit;
    logic [2:0]            wr_div;
    logic [FRAME_LOG2-1:0] wr_phase;

    // Low d bits set: selects the position within a 2^d-cycle period.
    function automatic logic [FRAME_LOG2-1:0] period_mask(input logic [2:0] d);
        logic [FRAME_LOG2-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < FRAME_LOG2; b++) begin
            m[b] = (3'(b) < d);
        end
        return m;
    endfunction

    function automatic logic [2:0] default_div(input int unsigned ch);
        if (ch == 0)      return 3'd0;
        else if (ch == 1) return 3'd1;
        else              return DIV_MAX;
    endfunction

    function automatic logic [FRAME_LOG2-1:0] default_phase(input int unsigned ch);
        if (ch == 0)      return '0;
        else if (ch == 1) return FRAME_LOG2'(1);
        else              return '1;
    endfunction

    // Boundary detection and sanitising of the incoming config write.
    always_comb begin
        last_slot = (cnt_q == '1);
        commit    = (state_q == ST_HALTED) || last_slot;
        cfg_hit   = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
        wr_div    = (cfg_div_log2 > DIV_MAX) ? DIV_MAX : cfg_div_log2;
        wr_phase  = cfg_phase & period_mask(wr_div);
    end

    // Halt / step state machine and frame counter next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            ST_RUN: begin
                if (last_slot && halt_req) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                cnt_d = '0;
                if (step)           state_d = ST_STEP;
                else if (!halt_req) state_d = ST_RUN;
            end
            ST_STEP: begin
                if (last_slot) state_d = halt_req ? ST_HALTED : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow/active config next-state. Commit copies the shadow as it stood
    // before this cycle's write, so a write in the commit cycle waits a frame.
    always_comb begin
        adiv_d = adiv_q;
        aph_d  = aph_q;
        sdiv_d = sdiv_q;
        sph_d  = sph_q;
        pend_d = pend_q;
        if (commit) begin
            adiv_d = sdiv_q;
            aph_d  = sph_q;
            pend_d = 1'b0;
        end
        if (cfg_hit) begin
            sdiv_d[cfg_ch] = wr_div;
            sph_d[cfg_ch]  = wr_phase;
            pend_d         = 1'b1;
        end
    end

    // State, counter and config registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                adiv_q[i] <= default_div(i);
                aph_q[i]  <= default_phase(i);
                sdiv_q[i] <= default_div(i);
                sph_q[i]  <= default_phase(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            adiv_q  <= adiv_d;
            aph_q   <= aph_d;
            sdiv_q  <= sdiv_d;
            sph_q   <= sph_d;
        end
    end

    // Outputs decoded from registered state, forced low while reset is high.
    always_comb begin
        logic running;
        running = !reset && (state_q != ST_HALTED);
        en      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            en[i] = running && ((cnt_q & period_mask(adiv_q[i])) == aph_q[i]);
        end
        frame_start = running && (cnt_q == '0);
        halted      = !reset && (state_q == ST_HALTED);
        cfg_pending = !reset && pend_q;
    end

endmodule

// File: tb/tb_clock_phase_sequencer.sv
// Scoreboard bench for clock_phase_sequencer: the stimulus process pushes the
// reference model's expected outputs for each cycle; the monitor pops and
// compares them at the falling edge.
module tb_clock_phase_sequencer;

    localparam int NUM_CH = 4;
    localparam int FL     = 2;
    localparam int FRAME  = 1 << FL;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [2:0]        cfg_div_log2;
    logic [FL-1:0]     cfg_phase;
    logic              halt_req;
    logic              step;
    logic [NUM_CH-1:0] en;
    logic              frame_start;
    logic              halted;
    logic              cfg_pending;

    always #5 clock = ~clock;

    clock_phase_sequencer #(
        .NUM_CH     (NUM_CH),
        .FRAME_LOG2 (FL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div_log2 (cfg_div_log2),
        .cfg_phase    (cfg_phase),
        .halt_req     (halt_req),
        .step         (step),
        .en           (en),
        .frame_start  (frame_start),
        .halted       (halted),
        .cfg_pending  (cfg_pending)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic              fs;
        logic              h;
        logic              p;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    // Reference model: mode 0 = running, 1 = halted, 2 = stepping.
    int m_mode;
    int m_cnt;
    int a_div[NUM_CH];
    int a_ph[NUM_CH];
    int s_div[NUM_CH];
    int s_ph[NUM_CH];
    bit m_pend;

    function automatic void model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_pend = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            a_div[i] = (i == 0) ? 0 : (i == 1) ? 1 : FL;
            a_ph[i]  = (i == 0) ? 0 : (i == 1) ? 1 : FRAME - 1;
            s_div[i] = a_div[i];
            s_ph[i]  = a_ph[i];
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        bit   running;
        o = '0;
        if (!reset) begin
            running = (m_mode != 1);
            for (int i = 0; i < NUM_CH; i++)
                o.en[i] = running && ((m_cnt % (1 << a_div[i])) == a_ph[i]);
            o.fs = running && (m_cnt == 0);
            o.h  = (m_mode == 1);
            o.p  = m_pend;
        end
        return o;
    endfunction

    function automatic void model_step();
        int next_mode;
        int d;
        bit boundary;
        if (reset) begin
            model_reset();
            return;
        end
        boundary = (m_cnt == FRAME - 1);
        if (m_mode == 1 || boundary) begin
            for (int i = 0; i < NUM_CH; i++) begin
                a_div[i] = s_div[i];
                a_ph[i]  = s_ph[i];
            end
            m_pend = 0;
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            d = (int'(cfg_div_log2) > FL) ? FL : int'(cfg_div_log2);
            s_div[cfg_ch] = d;
            s_ph[cfg_ch]  = int'(cfg_phase) % (1 << d);
            m_pend = 1;
        end
        next_mode = m_mode;
        case (m_mode)
            0: if (boundary && halt_req) next_mode = 1;
            1: if (step) next_mode = 2; else if (!halt_req) next_mode = 0;
            default: if (boundary) next_mode = halt_req ? 1 : 0;
        endcase
        m_cnt  = (m_mode == 1) ? 0 : (m_cnt + 1) % FRAME;
        m_mode = next_mode;
    endfunction

    // One clock cycle: queue the expectation, advance model at the edge,
    // then clear single-cycle pulses.
    task automatic cyc();
        exp_q.push_back(model_out());
        @(posedge clock);
        model_step();
        #1;
        cfg_we = 1'b0;
        step   = 1'b0;
    endtask

    task automatic align(input int c);
        for (int k = 0; k < FRAME && m_cnt != c; k++) cyc();
    endtask

    task automatic write_cfg(input int ch, input int dv, input int ph);
        cfg_we       = 1'b1;
        cfg_ch       = 2'(ch);
        cfg_div_log2 = 3'(dv);
        cfg_phase    = FL'(ph);
    endtask

    // Pulse-count window for the post-reset pattern.
    bit count_win = 0;
    bit prev_win  = 0;
    int cnt_en[NUM_CH];
    int cnt_fs = 0;
    int want_en[NUM_CH] = '{12, 6, 3, 3};

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clock) begin
        obs_t got;
        obs_t e;
        got = {en, frame_start, halted, cfg_pending};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle%0d outputs: got en=%b fs=%b halted=%b pend=%b, expected en=%b fs=%b halted=%b pend=%b",
                         cycle_no, got.en, got.fs, got.h, got.p, e.en, e.fs, e.h, e.p);
            end
            cycle_no++;
        end
        if (count_win) begin
            for (int i = 0; i < NUM_CH; i++) if (en[i] === 1'b1) cnt_en[i]++;
            if (frame_start === 1'b1) cnt_fs++;
        end else if (prev_win) begin
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (cnt_en[i] != want_en[i]) begin
                    errors++;
                    $display("FAIL pulse_count ch%0d: got %0d, expected %0d", i, cnt_en[i], want_en[i]);
                end
            end
            checks++;
            if (cnt_fs != 3) begin
                errors++;
                $display("FAIL frame_start_count: got %0d, expected 3", cnt_fs);
            end
        end
        prev_win = count_win;
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) cnt_en[i] = 0;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div_log2 = '0;
        cfg_phase = '0; halt_req = 1'b0; step = 1'b0;
        model_reset();
        @(posedge clock); #1;
        cyc(); cyc();
        reset = 1'b0;

        // Default pattern over three frames.
        count_win = 1;
        repeat (12) cyc();
        count_win = 0;

        // Halt mid-frame, step with halt held, release, step in RUN ignored.
        cyc();
        halt_req = 1'b1;
        repeat (3) cyc();
        repeat (2) cyc();
        step = 1'b1; cyc();
        repeat (6) cyc();
        halt_req = 1'b0; cyc();
        step = 1'b1; cyc();
        repeat (6) cyc();

        // Config write mid-frame, then one in the commit cycle with clamping.
        align(1);
        write_cfg(1, 2, 2); cyc();
        repeat (8) cyc();
        align(3);
        write_cfg(2, 7, 1); cyc();
        repeat (8) cyc();

        // Reset while stepping with a write pending.
        align(3);
        halt_req = 1'b1; cyc();
        step = 1'b1; cyc();
        write_cfg(3, 0, 0); cyc();
        reset = 1'b1; cyc();
        reset = 1'b0; halt_req = 1'b0;
        repeat (4) cyc();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            step = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0)
                write_cfg($urandom_range(0, NUM_CH - 1), $urandom_range(0, 7), $urandom_range(0, FRAME - 1));
            cyc();
        end
        reset = 1'b0;

        @(negedge clock); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
